// File: rtl/shift_acc_if.sv
// shift_acc_if -- beat input and result output handshakes of shift_acc.
//   in_valid / in_ready / psum        : bit-plane partial-sum stream, MSB plane first
//   out_valid / out_ready / out_data  : accumulated result
// Modports: master = producer/consumer side (drives beats, accepts results),
//           slave  = the accumulator.
interface shift_acc_if #(
    parameter int IN_W  = 13,
    parameter int OUT_W = 21
);
    logic             in_valid;
    logic             in_ready;
    logic [IN_W-1:0]  psum;
    logic             out_valid;
    logic             out_ready;
    logic [OUT_W-1:0] out_data;

    modport master (
        output in_valid, psum, out_ready,
        input  in_ready, out_valid, out_data
    );

    modport slave (
        input  in_valid, psum, out_ready,
        output in_ready, out_valid, out_data
    );
endinterface

// File: rtl/shift_acc.sv
// shift_acc -- bit-serial shift accumulator.
// Combines BITS partial sums (one per bit plane, MSB plane first) into
// acc = sum(psum_i * 2^(BITS-1-i)). In signed mode the MSB plane carries a
// negative weight, giving a two's-complement result.
// Ports:
//   clk    : clock, rising edge
//   rst_n  : asynchronous active-low reset
//   sus    : 1 = signed frame, 0 = unsigned; sampled on the first beat
//   clr    : synchronous frame abort, beats the handshakes in priority
//   busy   : high while a frame is partially accumulated
//   bus    : shift_acc_if.slave (beat stream in, result out)
module shift_acc #(
    parameter int IN_W  = 13,
    parameter int BITS  = 8,
    parameter int OUT_W = IN_W + BITS
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         sus,
    input  logic         clr,
    output logic         busy,
    shift_acc_if.slave   bus
);
    localparam int CNT_W = $clog2(BITS + 1);
    localparam logic [CNT_W-1:0] BITS_C = CNT_W'(BITS);

    typedef enum logic [1:0] {
        IDLE,
        ACC,
        DONE
    } state_t;

    state_t           state_reg, state_next;
    logic [OUT_W-1:0] acc_reg, acc_next;
    logic [CNT_W-1:0] cnt_reg, cnt_next;
    logic             sus_q_reg, sus_q_next;

    logic [CNT_W-1:0] cnt_inc;
    logic             ext_sign;
    logic [OUT_W-1:0] ext_val;

    // On the first beat sus_q is not yet loaded, so the live sus input
    // decides the extension; afterwards the latched mode is used.
    assign ext_sign = (state_reg == IDLE) ? sus : sus_q_reg;

    genvar gi;
    generate
        for (gi = 0; gi < OUT_W; gi++) begin : g_ext
            if (gi < IN_W) begin : g_low
                assign ext_val[gi] = bus.psum[gi];
            end else begin : g_high
                assign ext_val[gi] = ext_sign & bus.psum[IN_W-1];
            end
        end
    endgenerate

    assign cnt_inc = cnt_reg + CNT_W'(1);

    always_comb begin
        state_next = state_reg;
        acc_next   = acc_reg;
        cnt_next   = cnt_reg;
        sus_q_next = sus_q_reg;
        if (clr) begin
            state_next = IDLE;
            acc_next   = '0;
            cnt_next   = '0;
            sus_q_next = 1'b0;
        end else begin
            case (state_reg)
                IDLE: begin
                    if (bus.in_valid) begin
                        sus_q_next = sus;
                        // MSB plane has negative weight in signed mode
                        acc_next   = sus ? (-ext_val) : ext_val;
                        cnt_next   = CNT_W'(1);
                        state_next = (BITS_C == CNT_W'(1)) ? DONE : ACC;
                    end
                end
                ACC: begin
                    if (bus.in_valid) begin
                        acc_next = (acc_reg << 1) + ext_val;
                        cnt_next = cnt_inc;
                        if (cnt_inc == BITS_C) begin
                            state_next = DONE;
                        end
                    end
                end
                DONE: begin
                    if (bus.out_ready) begin
                        state_next = IDLE;
                        cnt_next   = '0;
                    end
                end
                default: begin
                    state_next = IDLE;
                end
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_reg <= IDLE;
            acc_reg   <= '0;
            cnt_reg   <= '0;
            sus_q_reg <= 1'b0;
        end else begin
            state_reg <= state_next;
            acc_reg   <= acc_next;
            cnt_reg   <= cnt_next;
            sus_q_reg <= sus_q_next;
        end
    end

    // Result is the accumulator itself, so it also holds through IDLE.
    assign bus.in_ready  = (state_reg != DONE);
    assign bus.out_valid = (state_reg == DONE);
    assign bus.out_data  = acc_reg;
    assign busy          = (state_reg == ACC);
endmodule

// File: tb/tb_shift_acc.sv
// tb_shift_acc -- randomized and directed stimulus for shift_acc with a
// scoreboard queue of expected results, drained by an independent monitor.
module tb_shift_acc;
    localparam int IN_W  = 13;
    localparam int BITS  = 8;
    localparam int OUT_W = IN_W + BITS;

    logic clk = 1'b0;
    logic rst_n;
    logic sus;
    logic clr;
    logic busy;

    logic bp_en = 1'b0;
    logic bp_rand = 1'b1;
    logic force_ready = 1'b1;
    bit   gaps_en = 1'b0;

    int checks = 0;
    int errors = 0;

    logic [OUT_W-1:0] sb[$];
    logic [IN_W-1:0]  frame_v[BITS];

    shift_acc_if #(.IN_W(IN_W), .OUT_W(OUT_W)) bus ();

    shift_acc #(.IN_W(IN_W), .BITS(BITS), .OUT_W(OUT_W)) dut (
        .clk  (clk),
        .rst_n(rst_n),
        .sus  (sus),
        .clr  (clr),
        .busy (busy),
        .bus  (bus.slave)
    );

    always #5 clk = ~clk;

    assign bus.out_ready = bp_en ? bp_rand : force_ready;

    always begin
        @(posedge clk);
        #1;
        bp_rand = 1'($urandom_range(0, 1));
    end

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Reference: weighted sum of planes, MSB plane negative in signed mode.
    function automatic logic [OUT_W-1:0] model(input bit s);
        longint r = 0;
        longint p;
        longint w;
        for (int i = 0; i < BITS; i++) begin
            p = s ? longint'($signed(frame_v[i])) : longint'(frame_v[i]);
            w = longint'(1) << (BITS - 1 - i);
            if (i == 0 && s) r = r - p * w;
            else             r = r + p * w;
        end
        return r[OUT_W-1:0];
    endfunction

    // Monitor: pops the scoreboard on each result handshake and checks that
    // a stalled result does not move.
    logic             stall_prev = 1'b0;
    logic [OUT_W-1:0] held = '0;
    logic [OUT_W-1:0] exp_res;
    always @(negedge clk) begin
        if (rst_n) begin
            if (bus.out_valid && stall_prev) chk("hold", 64'(bus.out_data), 64'(held));
            if (bus.out_valid && bus.out_ready) begin
                if (sb.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL unexpected_result: got %0h expected none", bus.out_data);
                end else begin
                    exp_res = sb.pop_front();
                    chk("result", 64'(bus.out_data), 64'(exp_res));
                    $display("result %0h expected %0h", bus.out_data, exp_res);
                end
            end
        end
        stall_prev = rst_n && bus.out_valid && !bus.out_ready;
        held       = bus.out_data;
    end

    task automatic send_frame(input bit s, input int nbeats, input bit do_push,
                              input logic [OUT_W-1:0] exp_val);
        if (do_push) sb.push_back(exp_val);
        for (int i = 0; i < nbeats; i++) begin
            while (gaps_en && $urandom_range(0, 3) == 0) begin
                bus.in_valid = 1'b0;
                bus.psum     = IN_W'($urandom);
                sus          = 1'($urandom);
                @(posedge clk);
                #1;
            end
            chk("in_ready", 64'(bus.in_ready), 64'd1);
            bus.in_valid = 1'b1;
            bus.psum     = frame_v[i];
            sus          = (i == 0) ? s : 1'($urandom);
            @(posedge clk);
            #1;
            bus.in_valid = 1'b0;
            if (i < BITS - 1) begin
                chk("busy", 64'(busy), 64'd1);
                chk("no_early_valid", 64'(bus.out_valid), 64'd0);
            end else begin
                chk("latency", 64'(bus.out_valid), 64'd1);
                chk("busy_done", 64'(busy), 64'd0);
            end
        end
    endtask

    task automatic wait_done();
        int n = 0;
        while (bus.out_valid && n < 100) begin
            @(posedge clk);
            #1;
            n++;
        end
        chk("drain", 64'(bus.out_valid), 64'd0);
    endtask

    task automatic fill(input logic [IN_W-1:0] v0, input logic [IN_W-1:0] vr);
        for (int i = 0; i < BITS; i++) frame_v[i] = (i == 0) ? v0 : vr;
    endtask

    task automatic fill_rand();
        for (int i = 0; i < BITS; i++) frame_v[i] = IN_W'($urandom);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        bit s;
        rst_n        = 1'b0;
        sus          = 1'b0;
        clr          = 1'b0;
        bus.in_valid = 1'b0;
        bus.psum     = '0;
        #3;
        chk("rst_out_valid", 64'(bus.out_valid), 64'd0);
        chk("rst_out_data", 64'(bus.out_data), 64'd0);
        chk("rst_busy", 64'(busy), 64'd0);
        chk("rst_in_ready", 64'(bus.in_ready), 64'd1);
        @(posedge clk);
        #1;
        rst_n = 1'b1;

        // Unsigned all-ones planes, back to back
        fill(13'd1, 13'd1);
        send_frame(1'b0, BITS, 1'b1, 21'd255);
        wait_done();

        // Unsigned max planes, held in DONE with beats offered
        force_ready = 1'b0;
        fill(13'h1FFF, 13'h1FFF);
        send_frame(1'b0, BITS, 1'b1, 21'd2088705);
        for (int k = 0; k < 5; k++) begin
            bus.in_valid = 1'b1;
            bus.psum     = IN_W'($urandom);
            @(posedge clk);
            #1;
            chk("stall_valid", 64'(bus.out_valid), 64'd1);
            chk("stall_in_ready", 64'(bus.in_ready), 64'd0);
            chk("stall_data", 64'(bus.out_data), 64'd2088705);
        end
        bus.in_valid = 1'b0;
        force_ready  = 1'b1;
        @(posedge clk);
        #1;
        chk("hs_idle_valid", 64'(bus.out_valid), 64'd0);
        chk("hs_idle_busy", 64'(busy), 64'd0);
        chk("hs_idle_data", 64'(bus.out_data), 64'd2088705);

        // Signed: +1 planes give -1; -1 MSB plane then zeros gives +128
        fill(13'd1, 13'd1);
        send_frame(1'b1, BITS, 1'b1, 21'h1FFFFF);
        wait_done();
        fill(13'h1FFF, 13'd0);
        send_frame(1'b1, BITS, 1'b1, 21'd128);
        wait_done();

        // Abort after beat 3 with a beat offered in the clr cycle
        fill_rand();
        send_frame(1'b1, 3, 1'b0, '0);
        bus.in_valid = 1'b1;
        bus.psum     = IN_W'($urandom);
        clr          = 1'b1;
        @(posedge clk);
        #1;
        clr          = 1'b0;
        bus.in_valid = 1'b0;
        chk("clr_busy", 64'(busy), 64'd0);
        chk("clr_valid", 64'(bus.out_valid), 64'd0);
        chk("clr_data", 64'(bus.out_data), 64'd0);
        fill_rand();
        send_frame(1'b0, BITS, 1'b1, model(1'b0));
        wait_done();

        // Reset mid-frame
        fill_rand();
        send_frame(1'b0, 4, 1'b0, '0);
        #2;
        rst_n = 1'b0;
        #1;
        chk("mrst_valid", 64'(bus.out_valid), 64'd0);
        chk("mrst_data", 64'(bus.out_data), 64'd0);
        chk("mrst_busy", 64'(busy), 64'd0);
        chk("mrst_in_ready", 64'(bus.in_ready), 64'd1);
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        fill_rand();
        send_frame(1'b1, BITS, 1'b1, model(1'b1));
        wait_done();

        // Reset while a result is waiting in DONE
        force_ready = 1'b0;
        fill_rand();
        send_frame(1'b0, BITS, 1'b0, '0);
        #2;
        rst_n = 1'b0;
        #1;
        chk("drst_valid", 64'(bus.out_valid), 64'd0);
        chk("drst_data", 64'(bus.out_data), 64'd0);
        @(posedge clk);
        #1;
        rst_n       = 1'b1;
        force_ready = 1'b1;

        // Randomized frames with gaps and back-pressure
        bp_en   = 1'b1;
        gaps_en = 1'b1;
        for (int f = 0; f < 40; f++) begin
            s = 1'($urandom);
            fill_rand();
            send_frame(s, BITS, 1'b1, model(s));
            wait_done();
        end

        @(posedge clk);
        #1;
        chk("sb_empty", 64'(sb.size()), 64'd0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule

// File: doc/shift_acc.md
SHIFT_ACC -- requirements
Module: shift_acc

Interface
REQ-001 The block SHALL expose parameter IN_W, default 13, as the partial-sum width (adder width + 1).
REQ-002 The block SHALL expose parameter BITS, default 8, as the number of bit-serial input planes per frame.
REQ-003 The block SHALL expose parameter OUT_W, default IN_W+BITS, as the result width.
REQ-004 The block SHALL have port clk, input, 1 bit, the single clock; all state SHALL be updated on its rising edge.
REQ-005 The block SHALL have port rst_n, input, 1 bit, an asynchronous active-low reset.
REQ-006 The block SHALL have port sus, input, 1 bit: 1 selects signed mode and 0 selects unsigned mode; it is sampled on the first beat of a frame.
REQ-007 The block SHALL have port clr, input, 1 bit, a synchronous frame abort.
REQ-008 The block SHALL have port in_valid, input, 1 bit, indicating that a partial-sum beat is present.
REQ-009 The block SHALL have port in_ready, output, 1 bit, indicating that the block can accept a beat.
REQ-010 The block SHALL have port psum, input, IN_W bits, the partial sum of one bit plane, presented MSB plane first.
REQ-011 The block SHALL have port out_valid, output, 1 bit, indicating that the result is valid.
REQ-012 The block SHALL have port out_ready, input, 1 bit, the downstream accept.
REQ-013 The block SHALL have port out_data, output, OUT_W bits, the accumulated result.
REQ-014 The block SHALL have port busy, output, 1 bit, high while a frame is partially accumulated.

Function
REQ-015 The FSM SHALL have three states: IDLE, ACC and DONE.
REQ-016 A beat SHALL be accepted when in_valid=1 and in_ready=1.
REQ-017 in_ready SHALL be 1 in IDLE and ACC, and 0 in DONE.
REQ-018 IDLE SHALL transition to ACC on an accepted beat; sus SHALL be latched into sus_q on that cycle.
REQ-019 Extension: ext(psum) SHALL be the sign-extension of psum to OUT_W when sus_q=1, and the zero-extension when sus_q=0.
REQ-020 First beat: acc SHALL be set to -ext(psum) when sus=1 (negative MSB weight), and to ext(psum) when sus=0.
REQ-021 Subsequent beats: acc SHALL be set to (acc<<1)+ext(psum), computed modulo 2^OUT_W.
REQ-022 A beat counter SHALL increment per accepted beat; after beat number BITS is accepted, the FSM SHALL enter DONE on the next edge.
REQ-023 With BITS=1, the first beat SHALL go directly from IDLE to DONE.
REQ-024 Cycles with in_valid=0 in ACC SHALL hold acc and the counter unchanged; gaps are allowed.
REQ-025 In DONE, out_valid SHALL be 1, and out_data SHALL equal acc and stay stable until out_valid=1 and out_ready=1.
REQ-026 On the DONE handshake, the FSM SHALL go to IDLE and the counter SHALL clear.
REQ-027 No beat SHALL be accepted in the handshake cycle.
REQ-028 The first beat of the next frame SHALL be accepted no earlier than one cycle after the handshake.
REQ-029 out_data SHALL hold its last value in IDLE.
REQ-030 clr=1 SHALL force IDLE and clear acc, the counter and sus_q on the next edge, in any state, and SHALL take priority over a beat or handshake in the same cycle.
REQ-031 Latency SHALL be 1 cycle from the last accepted beat to out_valid=1.
REQ-032 busy SHALL be 1 exactly in ACC.
REQ-033 sus changes after the first beat SHALL have no effect until the next frame.
REQ-034 No overflow flag SHALL exist; with default parameters the full range fits, and results otherwise wrap.

Reset
REQ-035 While rst_n=0, the block SHALL asynchronously force the FSM to IDLE and acc=0, counter=0, sus_q=0.
REQ-036 During reset, the outputs SHALL be out_valid=0, out_data=0, busy=0 and in_ready=1.
REQ-037 Reset deassertion SHALL be synchronous-safe; the first beat SHALL be accepted on the first rising edge with rst_n=1.
REQ-038 Reset mid-frame or in DONE SHALL discard the frame with no out_valid pulse.

Verification
REQ-039 The bench SHALL cover: sus=0, 8 beats psum=13'd1 back-to-back -> out_data=21'd255, with out_valid one cycle after beat 8.
REQ-040 The bench SHALL cover: sus=0, 8 beats psum=13'h1FFF -> out_data=21'd2088705.
REQ-041 The bench SHALL cover: sus=1, 8 beats psum=13'd1 -> out_data=21'h1FFFFF (-1).
REQ-042 The bench SHALL cover: sus=1, first beat psum=13'h1FFF (-1) then 7 beats of 0 -> out_data=21'd128.
REQ-043 The bench SHALL cover: out_ready held at 0 for 5 cycles in DONE -> out_valid and out_data stable, in_ready=0, and presented beats ignored; out_ready=1 -> IDLE next cycle.
REQ-044 The bench SHALL cover: clr after beat 3 with in_valid=1 in the same cycle -> beat ignored, busy=0 next cycle; the following full frame gives a correct result.
REQ-045 The bench SHALL cover: rst_n pulsed low mid-frame -> all outputs at reset values immediately; the subsequent frame is correct.
